// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter in front of one shared physical memory port.
// The instruction-fetch unit (IFU, read-only) and the load/store unit (LSU)
// compete for the memory. Only one transaction is in flight at a time.
// A transaction waits LATENCY cycles before the memory is accessed.
// The captured read data, or a zero acknowledge for a store, is then returned.
//
// Ports
//   clk, rst_n                     clock (rising edge), async active-low reset
//   ifu_req_valid/ready, ifu_addr  fetch request channel
//   ifu_resp_valid/ready, ifu_rdata fetch response channel
//   lsu_req_valid/ready, lsu_addr,
//   lsu_wen, lsu_wdata, lsu_wmask  load/store request channel
//   lsu_resp_valid/ready, lsu_rdata load data / store acknowledge channel
//   mem_raddr, mem_waddr, mem_wdata,
//   mem_wmask, mem_write, mem_rdata shared memory port (combinational read)
module mem_arbiter #(
   parameter int unsigned LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ifu_req_valid,
   output logic        ifu_req_ready,
   input  logic [63:0] ifu_addr,
   output logic        ifu_resp_valid,
   input  logic        ifu_resp_ready,
   output logic [63:0] ifu_rdata,
   input  logic        lsu_req_valid,
   output logic        lsu_req_ready,
   input  logic [63:0] lsu_addr,
   input  logic        lsu_wen,
   input  logic [63:0] lsu_wdata,
   input  logic [7:0]  lsu_wmask,
   output logic        lsu_resp_valid,
   input  logic        lsu_resp_ready,
   output logic [63:0] lsu_rdata,
   output logic [63:0] mem_raddr,
   output logic [63:0] mem_waddr,
   output logic [63:0] mem_wdata,
   output logic [7:0]  mem_wmask,
   output logic        mem_write,
   input  logic [63:0] mem_rdata
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

   state_e      state_q;
   logic [3:0]  cnt_q;
   logic        last_lsu_q;        // 1: LSU won the most recent handshake
   logic        id_lsu_q;          // requester of the transaction in flight
   logic        wen_q;
   logic        mem_write_q;
   logic        ifu_resp_valid_q;
   logic        lsu_resp_valid_q;
   logic [63:0] addr_q;
   logic [63:0] wdata_q;
   logic [63:0] resp_q;
   logic [7:0]  wmask_q;
   logic        gnt_ifu_d;
   logic        gnt_lsu_d;
   logic        resp_fire_d;

   // Grant selection in IDLE; ready equals grant, so a grant is a handshake.
   // Gated by rst_n so that neither ready can rise while reset is held.
   always_comb begin
      gnt_ifu_d = 1'b0;
      gnt_lsu_d = 1'b0;
      if (rst_n && (state_q == IDLE)) begin
         if (ifu_req_valid && lsu_req_valid) begin
            // Conflict: the requester that did not win last time goes first.
            if (last_lsu_q) begin
               gnt_ifu_d = 1'b1;
            end else begin
               gnt_lsu_d = 1'b1;
            end
         end else if (ifu_req_valid) begin
            gnt_ifu_d = 1'b1;
         end else if (lsu_req_valid) begin
            gnt_lsu_d = 1'b1;
         end else begin
            gnt_ifu_d = 1'b0;
         end
      end else begin
         gnt_lsu_d = 1'b0;
      end
   end

   assign resp_fire_d = (ifu_resp_valid_q & ifu_resp_ready) |
                        (lsu_resp_valid_q & lsu_resp_ready);

   // Transaction FSM: accept, wait out LATENCY cycles, access memory, respond.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q          <= IDLE;
         cnt_q            <= 4'd0;
         last_lsu_q       <= 1'b1;
         id_lsu_q         <= 1'b0;
         wen_q            <= 1'b0;
         mem_write_q      <= 1'b0;
         ifu_resp_valid_q <= 1'b0;
         lsu_resp_valid_q <= 1'b0;
         addr_q           <= 64'd0;
         wdata_q          <= 64'd0;
         wmask_q          <= 8'd0;
         resp_q           <= 64'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (gnt_ifu_d || gnt_lsu_d) begin
                  id_lsu_q    <= gnt_lsu_d;
                  last_lsu_q  <= gnt_lsu_d;
                  addr_q      <= gnt_lsu_d ? lsu_addr : ifu_addr;
                  wen_q       <= gnt_lsu_d & lsu_wen;
                  wdata_q     <= gnt_lsu_d ? lsu_wdata : 64'd0;
                  wmask_q     <= gnt_lsu_d ? lsu_wmask : 8'd0;
                  cnt_q       <= CNT_LOAD;
                  // With LATENCY 1 the very next cycle is the access cycle.
                  mem_write_q <= (CNT_LOAD == 4'd0) & gnt_lsu_d & lsu_wen;
                  state_q     <= WAIT;
               end else begin
                  state_q <= IDLE;
               end
            end
            WAIT: begin
               if (cnt_q == 4'd0) begin
                  // Access cycle: stores return an all-zero acknowledge.
                  resp_q           <= wen_q ? 64'd0 : mem_rdata;
                  mem_write_q      <= 1'b0;
                  ifu_resp_valid_q <= ~id_lsu_q;
                  lsu_resp_valid_q <= id_lsu_q;
                  state_q          <= RESP;
               end else begin
                  cnt_q       <= cnt_q - 4'd1;
                  // Raise the write strobe so that it covers the cycle in which cnt reaches 0.
                  mem_write_q <= wen_q & (cnt_q == 4'd1);
               end
            end
            RESP: begin
               if (resp_fire_d) begin
                  ifu_resp_valid_q <= 1'b0;
                  lsu_resp_valid_q <= 1'b0;
                  state_q          <= IDLE;
               end else begin
                  state_q <= RESP;
               end
            end
            default: begin
               state_q     <= IDLE;
               mem_write_q <= 1'b0;
            end
         endcase
      end
   end

   assign ifu_req_ready  = gnt_ifu_d;
   assign lsu_req_ready  = gnt_lsu_d;
   assign ifu_resp_valid = ifu_resp_valid_q;
   assign lsu_resp_valid = lsu_resp_valid_q;
   assign ifu_rdata      = resp_q;
   assign lsu_rdata      = resp_q;
   assign mem_raddr      = addr_q;
   assign mem_waddr      = addr_q;
   assign mem_wdata      = wdata_q;
   assign mem_wmask      = wmask_q;
   assign mem_write      = mem_write_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed table, corner-case sequences,
// and randomized transactions compared against a transaction-level model.
module tb_mem_arbiter;

   localparam int LAT = 2;

   logic        clk;
   logic        rst_n;
   logic        ifu_req_valid, ifu_req_ready;
   logic [63:0] ifu_addr;
   logic        ifu_resp_valid, ifu_resp_ready;
   logic [63:0] ifu_rdata;
   logic        lsu_req_valid, lsu_req_ready;
   logic [63:0] lsu_addr;
   logic        lsu_wen;
   logic [63:0] lsu_wdata;
   logic [7:0]  lsu_wmask;
   logic        lsu_resp_valid, lsu_resp_ready;
   logic [63:0] lsu_rdata;
   logic [63:0] mem_raddr, mem_waddr, mem_wdata;
   logic [7:0]  mem_wmask;
   logic        mem_write;
   logic [63:0] mem_rdata;

   int vectors = 0;
   int miscompares = 0;

   mem_arbiter #(.LATENCY(LAT)) dut (
      .clk(clk), .rst_n(rst_n),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
      .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_rdata(ifu_rdata),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
      .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
      .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_rdata(lsu_rdata),
      .mem_raddr(mem_raddr), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
      .mem_wmask(mem_wmask), .mem_write(mem_write), .mem_rdata(mem_rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // ---------------- physical memory (32 doublewords, index addr[7:3]) ----------
   function automatic logic [63:0] init_val(input int i);
      return (i == 0) ? 64'h13 : (64'h1111_0000_0000_0000 | 64'(i));
   endfunction

   function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] wd,
                                         input logic [7:0] wm);
      logic [63:0] r;
      r = old;
      for (int b = 0; b < 8; b++) if (wm[b]) r[8*b +: 8] = wd[8*b +: 8];
      return r;
   endfunction

   logic [63:0] phys [32];
   logic        written [32];

   always_comb begin
      mem_rdata = written[mem_raddr[7:3]] ? phys[mem_raddr[7:3]] : init_val(int'(mem_raddr[7:3]));
   end

   always @(posedge clk) begin
      if (mem_write) begin
         phys[mem_waddr[7:3]] <= merge(mem_rdata, mem_wdata, mem_wmask);
         written[mem_waddr[7:3]] <= 1'b1;
      end
   end

   initial begin
      for (int i = 0; i < 32; i++) written[i] = 1'b0;
   end

   // ---------------- reference model ----------------
   logic [63:0] shadow [32];
   logic        last_lsu_m;

   function automatic int model_winner(input logic iv, input logic lv);
      if (iv && lv) return last_lsu_m ? 0 : 1;
      return iv ? 0 : 1;
   endfunction

   task automatic model_apply(input int win, input logic [63:0] ia, input logic [63:0] la,
                              input logic lw, input logic [63:0] wd, input logic [7:0] wm,
                              output logic [63:0] exp_rd);
      if (win == 1 && lw) begin
         shadow[la[7:3]] = merge(shadow[la[7:3]], wd, wm);
         exp_rd = 64'd0;
      end else if (win == 1) begin
         exp_rd = shadow[la[7:3]];
      end else begin
         exp_rd = shadow[ia[7:3]];
      end
      last_lsu_m = (win == 1);
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One full transaction. Starts just after a rising edge.
   task automatic do_txn(input logic iv, input logic [63:0] ia, input logic lv,
                         input logic [63:0] la, input logic lw, input logic [63:0] lwd,
                         input logic [7:0] lwm, input int stall,
                         output int winner, output logic [63:0] rdata, output int lat,
                         output int nwr, output int bad);
      int cyc;
      bit got;
      logic [63:0] expaddr;
      winner = 2; rdata = 64'd0; lat = 0; nwr = 0; bad = 0;
      ifu_req_valid = iv; ifu_addr = ia;
      lsu_req_valid = lv; lsu_addr = la; lsu_wen = lw; lsu_wdata = lwd; lsu_wmask = lwm;
      cyc = 0;
      while (winner == 2 && cyc < 20) begin
         @(negedge clk);
         cyc++;
         if (ifu_req_valid && ifu_req_ready) winner = 0;
         else if (lsu_req_valid && lsu_req_ready) winner = 1;
         if (ifu_req_ready && lsu_req_ready) bad++;
      end
      @(posedge clk); #1;
      ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
      if (winner != 2) begin
         expaddr = (winner == 1) ? la : ia;
         got = 1'b0;
         while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            if (mem_write) begin
               nwr++;
               if (mem_waddr !== expaddr || mem_raddr !== expaddr || mem_wdata !== lwd ||
                   mem_wmask !== lwm || winner != 1 || !lw) bad++;
            end
            if ((winner == 0) ? ifu_resp_valid : lsu_resp_valid) got = 1'b1;
         end
         if (!got) lat = -1;
         rdata = (winner == 0) ? ifu_rdata : lsu_rdata;
         if ((winner == 0) ? lsu_resp_valid : ifu_resp_valid) bad++;
         if (stall > 0) begin
            ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
         end
         for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            if (!((winner == 0) ? ifu_resp_valid : lsu_resp_valid)) bad++;
            if (((winner == 0) ? ifu_rdata : lsu_rdata) !== rdata) bad++;
            if (mem_write || ifu_req_ready || lsu_req_ready) bad++;
         end
         if (winner == 0) ifu_resp_ready = 1'b1; else lsu_resp_ready = 1'b1;
         if (ifu_req_ready || lsu_req_ready) bad++;
         @(posedge clk); #1;
         ifu_resp_ready = 1'b0; lsu_resp_ready = 1'b0;
         ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
      end
   endtask

   typedef struct {
      logic        iv;
      logic [63:0] ia;
      logic        lv;
      logic [63:0] la;
      logic        lw;
      logic [63:0] wd;
      logic [7:0]  wm;
      int          exp_win;
      logic [63:0] exp_rdata;
      int          exp_nwr;
   } vec_t;

   vec_t tbl [10];

   initial begin
      int win, lat, nwr, bad, pw, n, cyc;
      int grants [4];
      logic [63:0] rd, erd, ia, la, wd;
      logic iv, lv, lw;
      logic [7:0] wm;

      tbl[0] = '{1'b1, 64'h8000_0000, 1'b0, 64'h0,         1'b0, 64'h0, 8'h00, 0, 64'h13, 0};
      tbl[1] = '{1'b0, 64'h0,         1'b1, 64'h8000_1000, 1'b1, 64'hDEAD_BEEF, 8'h0F, 1, 64'h0, 1};
      tbl[2] = '{1'b1, 64'h8000_0000, 1'b0, 64'h0,         1'b0, 64'h0, 8'h00, 0, 64'hDEAD_BEEF, 0};
      tbl[3] = '{1'b0, 64'h0,         1'b1, 64'h8000_0008, 1'b0, 64'h0, 8'h00, 1, 64'h1111_0000_0000_0001, 0};
      tbl[4] = '{1'b1, 64'h8000_0010, 1'b1, 64'h8000_0018, 1'b0, 64'h0, 8'h00, 0, 64'h1111_0000_0000_0002, 0};
      tbl[5] = '{1'b1, 64'h8000_0010, 1'b1, 64'h8000_0018, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 1, 64'h0, 1};
      tbl[6] = '{1'b0, 64'h0,         1'b1, 64'h8000_0018, 1'b0, 64'h0, 8'h00, 1, 64'h1111_0000_0000_0003, 0};
      tbl[7] = '{1'b1, 64'h8000_0020, 1'b1, 64'h8000_0028, 1'b0, 64'h0, 8'h00, 0, 64'h1111_0000_0000_0004, 0};
      tbl[8] = '{1'b0, 64'h0,         1'b1, 64'h8000_0020, 1'b1, 64'h0123_4567_89AB_CDEF, 8'hF0, 1, 64'h0, 1};
      tbl[9] = '{1'b1, 64'h8000_0020, 1'b0, 64'h0,         1'b0, 64'h0, 8'h00, 0, 64'h0123_4567_0000_0004, 0};

      for (int i = 0; i < 32; i++) shadow[i] = init_val(i);
      last_lsu_m = 1'b1;

      // Reset state, with both requesters already asking.
      rst_n = 1'b0;
      ifu_req_valid = 1'b1; ifu_addr = 64'h8000_0000; ifu_resp_ready = 1'b0;
      lsu_req_valid = 1'b1; lsu_addr = 64'h8000_0008; lsu_wen = 1'b1;
      lsu_wdata = 64'h0; lsu_wmask = 8'h00; lsu_resp_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_ifu_req_ready", 64'(ifu_req_ready), 64'd0);
      check("rst_lsu_req_ready", 64'(lsu_req_ready), 64'd0);
      check("rst_mem_write", 64'(mem_write), 64'd0);
      check("rst_resp_valids", {62'd0, ifu_resp_valid, lsu_resp_valid}, 64'd0);
      check("rst_rdata", ifu_rdata, 64'd0);
      check("rst_mem_raddr", mem_raddr, 64'd0);
      ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; lsu_wen = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed table.
      for (int i = 0; i < 10; i++) begin
         do_txn(tbl[i].iv, tbl[i].ia, tbl[i].lv, tbl[i].la, tbl[i].lw, tbl[i].wd, tbl[i].wm,
                0, win, rd, lat, nwr, bad);
         pw = model_winner(tbl[i].iv, tbl[i].lv);
         model_apply(pw, tbl[i].ia, tbl[i].la, tbl[i].lw, tbl[i].wd, tbl[i].wm, erd);
         check($sformatf("tbl%0d_winner", i), 64'(win), 64'(tbl[i].exp_win));
         check($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rdata);
         check($sformatf("tbl%0d_latency", i), 64'(lat), 64'(LAT + 1));
         check($sformatf("tbl%0d_writes", i), 64'(nwr), 64'(tbl[i].exp_nwr));
         check($sformatf("tbl%0d_protocol", i), 64'(bad), 64'd0);
      end

      // Both requesters valid continuously right after reset: IFU, LSU, IFU, LSU.
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      last_lsu_m = 1'b1;
      @(posedge clk); #1;
      ifu_req_valid = 1'b1; ifu_addr = 64'h8000_0008;
      lsu_req_valid = 1'b1; lsu_addr = 64'h8000_0028; lsu_wen = 1'b0;
      ifu_resp_ready = 1'b1; lsu_resp_ready = 1'b1;
      n = 0; cyc = 0;
      while (n < 4 && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (ifu_req_ready && ifu_req_valid) begin grants[n] = 0; n++; end
         else if (lsu_req_ready && lsu_req_valid) begin grants[n] = 1; n++; end
      end
      @(posedge clk); #1;
      ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
      repeat (LAT + 4) @(posedge clk);
      #1;
      ifu_resp_ready = 1'b0; lsu_resp_ready = 1'b0;
      check("rr_grant_count", 64'(n), 64'd4);
      for (int k = 0; k < n; k++) check($sformatf("rr_grant%0d", k), 64'(grants[k]), 64'(k % 2));
      last_lsu_m = 1'b1;

      // LSU response held off for 5 cycles while IFU keeps asking.
      do_txn(1'b0, 64'h0, 1'b1, 64'h8000_0008, 1'b0, 64'h0, 8'h00, 5, win, rd, lat, nwr, bad);
      pw = model_winner(1'b0, 1'b1);
      model_apply(pw, 64'h0, 64'h8000_0008, 1'b0, 64'h0, 8'h00, erd);
      check("stall_winner", 64'(win), 64'd1);
      check("stall_rdata", rd, 64'h1111_0000_0000_0001);
      check("stall_protocol", 64'(bad), 64'd0);

      // Reset during the WAIT phase of a store aborts it.
      lsu_req_valid = 1'b1; lsu_addr = 64'h8000_0030; lsu_wen = 1'b1;
      lsu_wdata = 64'hCAFE_F00D_CAFE_F00D; lsu_wmask = 8'hFF;
      @(negedge clk);
      check("abort_accept", 64'(lsu_req_ready), 64'd1);
      @(posedge clk); #1;
      lsu_req_valid = 1'b0; lsu_wen = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_rst_outputs",
            {58'd0, mem_write, ifu_resp_valid, lsu_resp_valid, ifu_req_ready, lsu_req_ready, 1'b0},
            64'd0);
      check("abort_rst_waddr", mem_waddr, 64'd0);
      nwr = 0; bad = 0;
      repeat (3) begin
         @(negedge clk);
         if (mem_write) nwr++;
      end
      rst_n = 1'b1;
      last_lsu_m = 1'b1;
      repeat (5) begin
         @(negedge clk);
         if (mem_write) nwr++;
         if (ifu_resp_valid || lsu_resp_valid) bad++;
      end
      check("abort_writes", 64'(nwr), 64'd0);
      check("abort_no_resp", 64'(bad), 64'd0);
      @(posedge clk); #1;
      do_txn(1'b1, 64'h8000_0030, 1'b0, 64'h0, 1'b0, 64'h0, 8'h00, 0, win, rd, lat, nwr, bad);
      pw = model_winner(1'b1, 1'b0);
      model_apply(pw, 64'h8000_0030, 64'h0, 1'b0, 64'h0, 8'h00, erd);
      check("post_abort_winner", 64'(win), 64'd0);
      check("post_abort_rdata", rd, init_val(6));
      check("post_abort_latency", 64'(lat), 64'(LAT + 1));

      // Randomized traffic against the model.
      for (int t = 0; t < 150; t++) begin
         iv = 1'($urandom_range(0, 1));
         lv = iv ? 1'($urandom_range(0, 1)) : 1'b1;
         ia = 64'h8000_0000 | (64'($urandom_range(0, 31)) << 3);
         la = 64'h8000_0000 | (64'($urandom_range(0, 31)) << 3);
         lw = 1'($urandom_range(0, 1));
         wd = {$urandom, $urandom};
         wm = 8'($urandom_range(0, 255));
         do_txn(iv, ia, lv, la, lw, wd, wm, $urandom_range(0, 2), win, rd, lat, nwr, bad);
         pw = model_winner(iv, lv);
         model_apply(pw, ia, la, lw, wd, wm, erd);
         check($sformatf("rnd%0d_winner", t), 64'(win), 64'(pw));
         check($sformatf("rnd%0d_rdata", t), rd, erd);
         check($sformatf("rnd%0d_latency", t), 64'(lat), 64'(LAT + 1));
         check($sformatf("rnd%0d_writes", t), 64'(nwr), 64'((pw == 1 && lw) ? 1 : 0));
         check($sformatf("rnd%0d_protocol", t), 64'(bad), 64'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
